// File: rtl/uart_csr_bridge.sv
// UART command-frame to CSR-bus initiator with CRC-8 framing and timeout.
// Optional BRIDGE_TX_CRC_EN appends a CRC-8 byte to every response.
module uart_csr_bridge #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              crc_en,
  output logic              csr_wen,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata,
  output logic              rx_crc_error,
  output logic              rx_illegal_cmd,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CRC,
    S_EXEC,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    K_ACK,
    K_NAK,
    K_RD
  } kind_t;

  localparam logic [7:0]  OP_WR   = 8'h01;
  localparam logic [7:0]  OP_RD   = 8'h02;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  function automatic logic [7:0] f_crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07)
               : {x[6:0], 1'b0};
    end
    return x;
  endfunction

  state_t              r_state;
  state_t              w_nxt;
  kind_t               r_kind;
  logic                r_is_wr;
  logic                r_crc_on;
  logic [7:0]          r_crc;
  logic [1:0]          r_cnt;
  logic [31:0]         r_to;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [2:0]          r_idx;
  logic                r_ill;
  logic                r_crc_err;

  logic                w_op_ok;
  logic                w_to_hit;
  logic                w_ill;
  logic                w_crc_bad;
  logic                w_last;
  logic [2:0]          w_last_idx;
  logic [7:0]          w_pay;
  logic [7:0]          w_byte;

  assign w_op_ok  = (rx_data == OP_WR) || (rx_data == OP_RD);
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_to == TO_LAST);

`ifdef BRIDGE_TX_CRC_EN
  logic [7:0] r_tx_crc;
  assign w_last_idx = (r_kind == K_RD) ? 3'd5 : 3'd1;
`else
  assign w_last_idx = (r_kind == K_RD) ? 3'd4 : 3'd0;
`endif

  assign w_last = (r_idx == w_last_idx);

  always_comb begin
    w_nxt     = r_state;
    w_ill     = 1'b0;
    w_crc_bad = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (w_op_ok) w_nxt = S_ADDR;
          else         w_ill = 1'b1;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (r_is_wr)       w_nxt = S_DATA;
          else if (r_crc_on) w_nxt = S_CRC;
          else               w_nxt = S_EXEC;
        end else if (w_to_hit) begin
          w_ill = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (r_cnt == 2'd3)
            w_nxt = r_crc_on ? S_CRC : S_EXEC;
        end else if (w_to_hit) begin
          w_ill = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          if (rx_data == r_crc) begin
            w_nxt = S_EXEC;
          end else begin
            w_crc_bad = 1'b1;
            w_nxt     = S_RESP;
          end
        end else if (w_to_hit) begin
          w_ill = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_ill = rx_valid;
        w_nxt = S_RESP;
      end
      S_RESP: begin
        w_ill = rx_valid;
        if (tx_ready && w_last) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pay = 8'h00;
    unique case (r_idx)
      3'd0: begin
        unique case (1'b1)
          (r_kind == K_ACK): w_pay = 8'hAC;
          (r_kind == K_NAK): w_pay = 8'hEE;
          default:           w_pay = 8'hAD;
        endcase
      end
      3'd1:    w_pay = r_rdata[7:0];
      3'd2:    w_pay = r_rdata[15:8];
      3'd3:    w_pay = r_rdata[23:16];
      3'd4:    w_pay = r_rdata[31:24];
      default: w_pay = 8'h00;
    endcase
  end

`ifdef BRIDGE_TX_CRC_EN
  assign w_byte = w_last ? r_tx_crc : w_pay;
`else
  assign w_byte = w_pay;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kind    <= K_ACK;
      r_is_wr   <= 1'b0;
      r_crc_on  <= 1'b0;
      r_crc     <= 8'h00;
      r_cnt     <= 2'd0;
      r_to      <= 32'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_idx     <= 3'd0;
      r_ill     <= 1'b0;
      r_crc_err <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_ill     <= w_ill;
      r_crc_err <= w_crc_bad;
      if (r_state inside {S_ADDR, S_DATA, S_CRC} && !rx_valid)
        r_to <= r_to + 32'd1;
      else
        r_to <= 32'd0;
      if (r_state != S_RESP)
        r_idx <= 3'd0;
      case (r_state)
        S_IDLE: begin
          r_crc <= 8'h00;
          if (rx_valid && w_op_ok) begin
            r_is_wr  <= (rx_data == OP_WR);
            r_crc_on <= crc_en;
            r_crc    <= f_crc8(8'h00, rx_data);
            r_cnt    <= 2'd0;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= ADDR_W'(rx_data);
            r_crc  <= f_crc8(r_crc, rx_data);
            r_kind <= r_is_wr ? K_ACK : K_RD;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data;
            r_crc <= f_crc8(r_crc, rx_data);
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_CRC: begin
          if (rx_valid && (rx_data != r_crc))
            r_kind <= K_NAK;
        end
        S_EXEC: begin
          if (!r_is_wr) r_rdata <= csr_rdata;
        end
        S_RESP: begin
          if (tx_ready) r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BRIDGE_TX_CRC_EN
  // Running CRC over the bytes already handed to the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tx_crc <= 8'h00;
    else if (r_state != S_RESP)
      r_tx_crc <= 8'h00;
    else if (tx_ready)
      r_tx_crc <= f_crc8(r_tx_crc, w_pay);
  end
`endif

  assign tx_valid       = (r_state == S_RESP);
  assign tx_data        = tx_valid ? w_byte : 8'h00;
  assign csr_wen        = (r_state == S_EXEC) && r_is_wr;
  assign csr_ren        = (r_state == S_EXEC) && !r_is_wr;
  assign csr_addr       = r_addr;
  assign csr_wdata      = r_wdata;
  assign rx_crc_error   = r_crc_err;
  assign rx_illegal_cmd = r_ill;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: framing, CRC, timeout,
// back-pressure, overrun and mid-frame reset.
module tb_uart_csr_bridge;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        crc_en;
  logic        csr_wen;
  logic        csr_ren;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        rx_crc_error;
  logic        rx_illegal_cmd;
  logic        busy;

  int total;
  int bad;
  int n_wen, n_ren, n_ill, n_crc, n_both, n_long;
  logic p_wen, p_ren, p_ill, p_crc;
  logic [7:0] txq[$];
  logic [7:0] expq[$];

  uart_csr_bridge #(
    .ADDR_W(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .crc_en(crc_en),
    .csr_wen(csr_wen),
    .csr_ren(csr_ren),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .rx_crc_error(rx_crc_error),
    .rx_illegal_cmd(rx_illegal_cmd),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2ns after posedge, so negedge sees a stable pre-edge view.
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_wen) n_wen++;
      if (csr_ren) n_ren++;
      if (rx_illegal_cmd) n_ill++;
      if (rx_crc_error) n_crc++;
      if (csr_wen && csr_ren) n_both++;
      if ((csr_wen && p_wen) || (csr_ren && p_ren) ||
          (rx_illegal_cmd && p_ill) || (rx_crc_error && p_crc))
        n_long++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
    end
    p_wen = csr_wen;
    p_ren = csr_ren;
    p_ill = rx_illegal_cmd;
    p_crc = rx_crc_error;
  end

  function automatic logic [7:0] crc8(input logic [7:0] c,
                                      input logic [7:0] d);
    logic [7:0] x;
    x = c;
    for (int b = 7; b >= 0; b--) begin
      if (x[7] ^ d[b]) x = {x[6:0], 1'b0} ^ 8'h07;
      else             x = {x[6:0], 1'b0};
    end
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic collect(input string name);
    int n;
    logic [7:0] c;
    n = 0;
    tx_ready = 1'b1;
`ifdef BRIDGE_TX_CRC_EN
    c = 8'h00;
    foreach (expq[i]) c = crc8(c, expq[i]);
    expq.push_back(c);
`else
    c = 8'h00;
`endif
    while ((busy || txq.size() < expq.size()) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s_wait: got %0d cycles want <60", name, n);
    end
    total++;
    if (txq.size() != expq.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d want %0d", name,
               txq.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        total++;
        if (txq[i] !== expq[i]) begin
          bad++;
          $display("FAIL %s_byte%0d: got %h want %h", name, i,
                   txq[i], expq[i]);
        end
      end
    end
    txq.delete();
    expq.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({tx_valid, tx_data, csr_wen, csr_ren, rx_crc_error,
         rx_illegal_cmd, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0",
               {tx_valid, tx_data, csr_wen, csr_ren, rx_crc_error,
                rx_illegal_cmd, busy});
    end
    total++;
    if ({csr_addr, csr_wdata} !== 40'd0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {csr_addr, csr_wdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write;
    int w0;
    w0 = n_wen;
    crc_en = 1'b0;
    txq.delete();
    send_byte(8'h01);
    chk("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h10);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("wr_wen", {30'd0, csr_wen, csr_ren}, 32'd2);
    chk("wr_addr", 32'(csr_addr), 32'h10);
    chk("wr_wdata", csr_wdata, 32'h0000_0004);
    tick();
    chk("wr_wen_drop", 32'(csr_wen), 32'd0);
    chk("wr_txv", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAC});
    expq = '{8'hAC};
    collect("wr_tx");
    chk("wr_idle", 32'(busy), 32'd0);
    chk("wr_nwen", 32'(n_wen - w0), 32'd1);
  endtask

  task automatic test_read_crc;
    int r0;
    r0 = n_ren;
    crc_en    = 1'b1;
    csr_rdata = 32'h3F80_0000;
    txq.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h2A);
    chk("rd_ren", {30'd0, csr_wen, csr_ren}, 32'd1);
    expq = '{8'hAD, 8'h00, 8'h00, 8'h80, 8'h3F};
    collect("rd_tx");
    chk("rd_nren", 32'(n_ren - r0), 32'd1);
  endtask

  task automatic test_crc_bad;
    int r0, c0;
    r0 = n_ren;
    c0 = n_crc;
    crc_en = 1'b1;
    txq.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h2B);
    chk("crc_err_pulse", 32'(rx_crc_error), 32'd1);
    chk("crc_no_ren", 32'(csr_ren), 32'd0);
    expq = '{8'hEE};
    collect("crc_tx");
    chk("crc_nren", 32'(n_ren - r0), 32'd0);
    chk("crc_ncrc", 32'(n_crc - c0), 32'd1);
  endtask

  task automatic test_illegal;
    int i0;
    i0 = n_ill;
    crc_en = 1'b0;
    txq.delete();
    send_byte(8'h7F);
    chk("ill_pulse", 32'(rx_illegal_cmd), 32'd1);
    chk("ill_idle", 32'(busy), 32'd0);
    tick();
    chk("ill_drop", 32'(rx_illegal_cmd), 32'd0);
    send_byte(8'h01);
    send_byte(8'h22);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("ill_wr_wen", 32'(csr_wen), 32'd1);
    chk("ill_wr_data", csr_wdata, 32'h1234_5678);
    chk("ill_wr_addr", 32'(csr_addr), 32'h22);
    expq = '{8'hAC};
    collect("ill_tx");
    chk("ill_count", 32'(n_ill - i0), 32'd1);
  endtask

  task automatic test_timeout;
    int i0, w0;
    i0 = n_ill;
    w0 = n_wen;
    crc_en = 1'b0;
    txq.delete();
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (15) tick();
    chk("to_still_busy", 32'(busy), 32'd1);
    tick();
    chk("to_fire", {30'd0, busy, rx_illegal_cmd}, 32'd1);
    repeat (4) tick();
    chk("to_no_tx", 32'(txq.size()), 32'd0);
    chk("to_no_wen", 32'(n_wen - w0), 32'd0);
    chk("to_ill", 32'(n_ill - i0), 32'd1);
    i0 = n_ill;
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (15) tick();
    send_byte(8'hAA);
    chk("to_edge_accept", {30'd0, busy, rx_illegal_cmd}, 32'd2);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    chk("to_edge_wen", 32'(csr_wen), 32'd1);
    chk("to_edge_data", csr_wdata, 32'hDDCC_BBAA);
    expq = '{8'hAC};
    collect("to_edge_tx");
    chk("to_edge_ill", 32'(n_ill - i0), 32'd0);
  endtask

  task automatic test_backpressure;
    crc_en    = 1'b0;
    csr_rdata = 32'hA1B2_C3D4;
    txq.delete();
    tx_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'h05);
    chk("bp_ren", 32'(csr_ren), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        send_byte(8'h55);
        chk("bp_overrun", 32'(rx_illegal_cmd), 32'd1);
      end else begin
        tick();
      end
      chk("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAD});
    end
    expq = '{8'hAD, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    collect("bp_tx");
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = n_wen;
    crc_en = 1'b0;
    txq.delete();
    send_byte(8'h01);
    send_byte(8'h30);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    chk("rm_ctl", {28'd0, busy, csr_wen, tx_valid, rx_illegal_cmd},
        32'd0);
    chk("rm_data", csr_wdata, 32'd0);
    chk("rm_addr", 32'(csr_addr), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("rm_no_wen", 32'(n_wen - w0), 32'd0);
    send_byte(8'h01);
    send_byte(8'h44);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    chk("rm_wr_wen", 32'(csr_wen), 32'd1);
    chk("rm_wr_data", csr_wdata, 32'hDEAD_BEEF);
    chk("rm_wr_addr", 32'(csr_addr), 32'h44);
    expq = '{8'hAC};
    collect("rm_tx");
    chk("rm_nwen", 32'(n_wen - w0), 32'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    n_wen    = 0;
    n_ren    = 0;
    n_ill    = 0;
    n_crc    = 0;
    n_both   = 0;
    n_long   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    crc_en   = 1'b0;
    csr_rdata = 32'd0;
    test_reset();
    test_write();
    test_read_crc();
    test_crc_bad();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    chk("both_strobes", 32'(n_both), 32'd0);
    chk("long_pulses", 32'(n_long), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_csr_bridge.md
Name: uart_csr_bridge

Overview:
- Host-side initiator for the accelerator CSR bus.
- Parses command frames from the UART RX byte stream, issues single-cycle csr_wen/csr_ren strobes to the CSR block, and returns ack/read-data frames on the UART TX byte stream.
- Drives the CSR block's rx_crc_error and rx_illegal_cmd event inputs.
- Takes uart_crc_en from the CSR block.

Parameters:
- ADDR_W, 8, CSR byte-address width; must match the CSR block.
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready.
- crc_en  in  1  frame CRC checking enable.
- csr_wen  out  1  CSR write strobe.
- csr_ren  out  1  CSR read strobe.
- csr_addr  out  ADDR_W  CSR byte address.
- csr_wdata  out  32  CSR write data.
- csr_rdata  in  32  CSR read data, combinational from csr_addr.
- rx_crc_error  out  1  one-cycle pulse on CRC mismatch.
- rx_illegal_cmd  out  1  one-cycle pulse on bad opcode, overrun or timeout.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - All outputs are 0; FSM is in IDLE.
  - csr_addr and csr_wdata are 0; CRC accumulator is 0x00.
  - Reset mid-frame or mid-response aborts immediately; no partial strobe is issued.
- Request frame, bytes in order: OP, ADDR, DATA0..DATA3 (write only, little-endian), CRC (only when crc_en=1).
  - OP 0x01 = write, OP 0x02 = read.
  - csr_addr takes the ADDR byte zero-extended or truncated to ADDR_W.
  - crc_en is sampled when OP is accepted and held for the whole frame.
- CRC-8:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over OP, ADDR and the DATA bytes.
  - Accumulator is cleared in IDLE.
- FSM states: IDLE, ADDR, DATA, CRC, EXEC, RESP.
  - IDLE: on rx_valid with OP 0x01 or 0x02, go to ADDR. Any other byte pulses rx_illegal_cmd and stays in IDLE.
  - ADDR: capture ADDR. Go to DATA for a write, else to CRC if crc_en, else to EXEC.
  - DATA: a 2-bit counter places bytes into csr_wdata[8i+7:8i]. After DATA3, go to CRC if crc_en, else to EXEC.
  - CRC on match: go to EXEC.
  - CRC on mismatch: pulse rx_crc_error, issue no CSR access, queue the NAK byte 0xEE, and go to RESP.
  - EXEC (exactly one cycle):
    - Write: csr_wen=1 with csr_addr/csr_wdata stable; response is the single byte 0xAC.
    - Read: csr_ren=1 and csr_rdata captured on the same edge; response is 0xAD then rdata bytes [7:0], [15:8], [23:16], [31:24].
    - Go to RESP.
  - RESP: present bytes in order with tx_valid=1. tx_data stays stable while tx_valid && !tx_ready. Return to IDLE after the last handshake. tx_valid may be held high across consecutive bytes.
- Latency: the CSR strobe occurs exactly 1 cycle after the final request byte's rx_valid; tx_valid rises 1 cycle after the strobe.
- Overrun: an rx_valid in EXEC or RESP discards the byte and pulses rx_illegal_cmd. The response is unaffected.
- Timeout:
  - In ADDR, DATA or CRC, a counter increments each cycle and clears on every accepted byte.
  - When it reaches TIMEOUT_CYC (if nonzero), pulse rx_illegal_cmd, go to IDLE, and send no response.
  - An rx_valid arriving in the same cycle the counter expires is accepted; the timeout does not fire.
- Strobes and pulses are never asserted for more than 1 cycle per event. csr_wen and csr_ren are never both high.

Optional Feature:
- Macro: BRIDGE_TX_CRC_EN.
- When defined: every response (ACK, NAK, read data) is followed by one CRC-8 byte, using the same polynomial and init, computed over that response's preceding bytes. This happens regardless of crc_en.
- When undefined: responses are as specified above with no trailing byte. The TX CRC logic is absent.

Test Plan:
- crc_en=0, write frame 01 10 04 00 00 00 -> one-cycle csr_wen with csr_addr=0x10 and csr_wdata=0x00000004; TX sends AC; busy returns to 0.
- crc_en=1, csr_rdata=0x3F800000, read frame 02 00 2A -> one-cycle csr_ren; TX sends AD 00 00 80 3F.
- crc_en=1, read frame 02 00 2B -> rx_crc_error pulses once; no csr_ren; TX sends EE.
- Byte 0x7F in IDLE -> rx_illegal_cmd pulses once; FSM stays in IDLE; then a valid write completes normally.
- TIMEOUT_CYC=16, send 01 10 then idle for 16 cycles -> rx_illegal_cmd pulses and the FSM returns to IDLE with no TX. Then, with tx_ready held 0 for 5 cycles during a read response, tx_data stays stable and an rx byte arriving meanwhile pulses rx_illegal_cmd.
- Assert rst_n=0 during the DATA state -> all outputs are 0 immediately; after release, a full write frame works and no stale csr_wen is issued.
